fifo9_gmii_tx: RTL and testbench
================================

FIFO9_GMII_TX -- requirements
Module: fifo9_gmii_tx

Interface
REQ-001 Parameter PREAMBLE_LEN, default 7: number of 0x55 preamble bytes sent before the SFD.
REQ-002 Parameter MIN_FRAME, default 60: minimum payload bytes per frame; short frames are padded up to this length.
REQ-003 Parameter PAD_EN, default 1: 1 enables padding; 0 sends frames unpadded.
REQ-004 Parameter IFG_CYCLES, default 12: number of idle cycles (tx_en=0) after every frame, including aborted ones.
REQ-005 gmii_tx_clk  in  1  sole clock, 125 MHz; all logic on its rising edge.
REQ-006 sys_rst_n  in  1  reset, synchronous, active-low.
REQ-007 dout  in  9  first-word-fall-through FIFO word; [7:0] byte, [8]=1 marks last byte of frame.
REQ-008 empty  in  1  FIFO empty; dout is valid only when empty=0.
REQ-009 rd_en  out  1  FIFO pop; consumes the current dout at the rising edge.
REQ-010 rd_clk  out  1  FIFO read clock, equal to gmii_tx_clk.
REQ-011 gmii_tx_en  out  1  GMII transmit enable, registered.
REQ-012 gmii_tx_er  out  1  GMII transmit error, registered.
REQ-013 gmii_txd  out  8  GMII transmit data, registered.
REQ-014 frame_cnt  out  16  count of frames completed without error; wraps at 0xFFFF->0.
REQ-015 underrun_cnt  out  16  count of aborted frames; saturates at 0xFFFF.

Function
REQ-016 The FSM SHALL have the states IDLE, PRE, SFD, DATA, PAD, ABORT, DRAIN and IFG.
REQ-017 IDLE: tx_en=0; if empty=0, go to PRE without popping; the first 0x55 appears on gmii_txd with tx_en=1 on the next cycle.
REQ-018 PRE: drive 0x55 for exactly PREAMBLE_LEN cycles, then SFD; SFD drives 0xD5 for one cycle, then DATA.
REQ-019 DATA: rd_en = (state==DATA && empty==0), combinational; the popped dout[7:0] appears on gmii_txd the next cycle with tx_en=1.
REQ-020 DATA: a byte counter (11 bits, saturating at 2047) counts the bytes sent, is cleared in IDLE, and includes pad bytes.
REQ-021 DATA, pop with dout[8]=1: if PAD_EN=1 and count after this byte < MIN_FRAME, go to PAD; otherwise go to IFG and increment frame_cnt.
REQ-022 PAD: drive 0x00 with tx_en=1 until the count reaches MIN_FRAME, then go to IFG and increment frame_cnt; no pops occur in PAD.
REQ-023 DATA with empty=1 (underrun): go to ABORT; ABORT drives tx_en=1, tx_er=1, txd=0x00 for one cycle and increments underrun_cnt.
REQ-024 After ABORT, go to DRAIN; DRAIN keeps tx_en=0 and pops (rd_en=!empty) until a word with dout[8]=1 is popped, then goes to IFG.
REQ-025 A word popped in the ABORT cycle SHALL NOT occur: rd_en=0 in every state except DATA and DRAIN.
REQ-026 IFG: tx_en=0, tx_er=0 for exactly IFG_CYCLES cycles, then IDLE; empty is ignored during IFG.
REQ-027 gmii_tx_er SHALL be 0 in every state except ABORT; gmii_txd SHALL be 0x00 whenever tx_en=0.
REQ-028 A frame whose first data word has dout[8]=1 is legal: it is a 1-byte payload, padded to MIN_FRAME when PAD_EN=1.
REQ-029 Wire frame length in cycles = PREAMBLE_LEN + 1 + max(payload, MIN_FRAME·PAD_EN); no FCS is generated (the FCS comes from the FIFO).

Reset
REQ-030 With sys_rst_n=0 at a clock edge: state=IDLE, gmii_tx_en=0, gmii_tx_er=0, gmii_txd=0x00, rd_en=0, counters=0.
REQ-031 A reset asserted mid-frame aborts immediately without tx_er and without DRAIN; remaining FIFO words are the responsibility of the FIFO owner.

Verification
REQ-032 One 64-byte frame (bytes 0x00..0x3F, last word [8]=1), defaults -> 7×0x55, 0xD5, 64 bytes in order, tx_en low for 12 cycles; frame_cnt=1.
REQ-033 A 10-byte frame, PAD_EN=1 -> 10 data bytes followed by 50×0x00, 60 tx_en data cycles total; with PAD_EN=0 -> only 10 data bytes.
REQ-034 Two back-to-back frames with the FIFO always non-empty -> exactly 12 idle cycles between the end of frame 1 and the 0x55 of frame 2.
REQ-035 empty=1 after the 5th data byte, frame tail arriving later -> one cycle tx_en=1/tx_er=1, tail discarded up to [8]=1, IFG; underrun_cnt=1, frame_cnt unchanged.
REQ-036 sys_rst_n=0 for 1 cycle during DATA -> all outputs 0 next cycle; a new frame then starts cleanly with a preamble.
REQ-037 A 1-byte frame ([8]=1 on the first word) -> 1 data byte plus 59 pad bytes; frame_cnt increments.

Source files
------------

// File: rtl/fifo9_gmii_tx.sv
// GMII transmitter fed by a 9-bit first-word-fall-through FIFO.
// Adds preamble/SFD, pads short frames, aborts on underrun and spaces frames by an IFG.
//
// state | meaning
// IDLE  | waiting for a non-empty FIFO; first preamble byte loaded on exit
// PRE   | remaining preamble bytes (0x55)
// SFD   | start-of-frame delimiter (0xD5)
// DATA  | popping payload bytes onto the wire
// PAD   | zero bytes until the minimum frame length is reached
// ABORT | one tx_er cycle on the wire after an underrun
// DRAIN | discarding the rest of the aborted frame from the FIFO
// IFG   | inter-frame gap, tx_en low
module fifo9_gmii_tx #(
    parameter int PREAMBLE_LEN = 7,
    parameter int MIN_FRAME    = 60,
    parameter int PAD_EN       = 1,
    parameter int IFG_CYCLES   = 12
) (
    input  logic        gmii_tx_clk,
    input  logic        sys_rst_n,
    input  logic [8:0]  dout,
    input  logic        empty,
    output logic        rd_en,
    output logic        rd_clk,
    output logic        gmii_tx_en,
    output logic        gmii_tx_er,
    output logic [7:0]  gmii_txd,
    output logic [15:0] frame_cnt,
    output logic [15:0] underrun_cnt
);

    typedef enum logic [2:0] {IDLE, PRE, SFD, DATA, PAD, ABORT, DRAIN, IFG} state_t;

    localparam logic [15:0] PRE_LOAD = 16'(PREAMBLE_LEN - 2);
    localparam logic [15:0] IFG_LOAD = 16'(IFG_CYCLES - 1);
    localparam logic [10:0] MIN_LEN  = 11'(MIN_FRAME);

    state_t      state, state_nxt;
    logic [15:0] tmr, tmr_nxt;
    logic [10:0] byte_cnt, cnt_nxt, cnt_inc;
    logic        en_nxt, er_nxt;
    logic [7:0]  txd_nxt;
    logic        rd_req, frame_inc, under_inc;

    assign rd_clk  = gmii_tx_clk;
    assign cnt_inc = (byte_cnt == 11'h7FF) ? byte_cnt : byte_cnt + 11'd1;
    // Gated by reset so nothing is popped on the edge that resets the FSM.
    assign rd_en   = sys_rst_n & rd_req;

    always_ff @(posedge gmii_tx_clk) begin
        if (!sys_rst_n) begin
            state        <= IDLE;
            tmr          <= '0;
            byte_cnt     <= '0;
            gmii_tx_en   <= 1'b0;
            gmii_tx_er   <= 1'b0;
            gmii_txd     <= 8'h00;
            frame_cnt    <= '0;
            underrun_cnt <= '0;
        end else begin
            state      <= state_nxt;
            tmr        <= tmr_nxt;
            byte_cnt   <= cnt_nxt;
            gmii_tx_en <= en_nxt;
            gmii_tx_er <= er_nxt;
            gmii_txd   <= txd_nxt;
            if (frame_inc)
                frame_cnt <= frame_cnt + 16'd1;
            if (under_inc && underrun_cnt != 16'hFFFF)
                underrun_cnt <= underrun_cnt + 16'd1;
        end
    end

    // Output registers are loaded with what the wire shows next cycle.
    always_comb begin
        state_nxt = state;
        tmr_nxt   = tmr;
        cnt_nxt   = byte_cnt;
        en_nxt    = 1'b0;
        er_nxt    = 1'b0;
        txd_nxt   = 8'h00;
        rd_req    = 1'b0;
        frame_inc = 1'b0;
        under_inc = 1'b0;
        case (state)
            IDLE: begin
                cnt_nxt = '0;
                if (!empty) begin
                    en_nxt  = 1'b1;
                    txd_nxt = 8'h55;
                    if (PREAMBLE_LEN > 1) begin
                        state_nxt = PRE;
                        tmr_nxt   = PRE_LOAD;
                    end else begin
                        state_nxt = SFD;
                    end
                end
            end
            PRE: begin
                en_nxt  = 1'b1;
                txd_nxt = 8'h55;
                if (tmr == 16'd0) state_nxt = SFD;
                else              tmr_nxt   = tmr - 16'd1;
            end
            SFD: begin
                en_nxt    = 1'b1;
                txd_nxt   = 8'hD5;
                state_nxt = DATA;
            end
            DATA: begin
                en_nxt = 1'b1;
                if (!empty) begin
                    rd_req  = 1'b1;
                    txd_nxt = dout[7:0];
                    cnt_nxt = cnt_inc;
                    if (dout[8]) begin
                        if (PAD_EN != 0 && cnt_inc < MIN_LEN) begin
                            state_nxt = PAD;
                        end else begin
                            state_nxt = IFG;
                            tmr_nxt   = IFG_LOAD;
                            frame_inc = 1'b1;
                        end
                    end
                end else begin
                    // Underrun: the error byte follows the last good byte directly.
                    er_nxt    = 1'b1;
                    state_nxt = ABORT;
                end
            end
            PAD: begin
                en_nxt  = 1'b1;
                cnt_nxt = cnt_inc;
                if (cnt_inc >= MIN_LEN) begin
                    state_nxt = IFG;
                    tmr_nxt   = IFG_LOAD;
                    frame_inc = 1'b1;
                end
            end
            ABORT: begin
                under_inc = 1'b1;
                state_nxt = DRAIN;
            end
            DRAIN: begin
                if (!empty) begin
                    rd_req = 1'b1;
                    if (dout[8]) begin
                        state_nxt = IFG;
                        tmr_nxt   = IFG_LOAD;
                    end
                end
            end
            IFG: begin
                if (tmr == 16'd0) state_nxt = IDLE;
                else              tmr_nxt   = tmr - 16'd1;
            end
            default: state_nxt = IDLE;
        endcase
    end

endmodule

// File: tb/tb_fifo9_gmii_tx.sv
// Directed bench: FWFT FIFO models feed a padded and an unpadded transmitter;
// the wire is logged every cycle and compared against hand-built byte streams.
module tb_fifo9_gmii_tx;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #4 clk = ~clk;

    logic [8:0]  dout0, dout1;
    logic        empty0, empty1, rd_en0, rd_en1, rd_clk0, rd_clk1;
    logic        en0, er0, en1, er1;
    logic [7:0]  txd0, txd1;
    logic [15:0] fcnt0, ucnt0, fcnt1, ucnt1;

    fifo9_gmii_tx u_pad (
        .gmii_tx_clk(clk), .sys_rst_n(rst_n), .dout(dout0), .empty(empty0),
        .rd_en(rd_en0), .rd_clk(rd_clk0), .gmii_tx_en(en0), .gmii_tx_er(er0),
        .gmii_txd(txd0), .frame_cnt(fcnt0), .underrun_cnt(ucnt0)
    );

    fifo9_gmii_tx #(.PAD_EN(0)) u_nopad (
        .gmii_tx_clk(clk), .sys_rst_n(rst_n), .dout(dout1), .empty(empty1),
        .rd_en(rd_en1), .rd_clk(rd_clk1), .gmii_tx_en(en1), .gmii_tx_er(er1),
        .gmii_txd(txd1), .frame_cnt(fcnt1), .underrun_cnt(ucnt1)
    );

    // FWFT FIFO models
    logic [8:0] mem0 [0:1023];
    logic [8:0] mem1 [0:1023];
    int  wp0 = 0, rp0 = 0, wp1 = 0, rp1 = 0;
    logic flush0 = 1'b0;
    logic pop_empty = 1'b0;

    assign empty0 = (rp0 == wp0);
    assign empty1 = (rp1 == wp1);
    assign dout0  = mem0[rp0[9:0]];
    assign dout1  = mem1[rp1[9:0]];

    always @(posedge clk) begin
        if (flush0)      rp0 <= wp0;
        else if (rd_en0) rp0 <= rp0 + 1;
        if (rd_en1)      rp1 <= rp1 + 1;
        if ((rd_en0 && empty0) || (rd_en1 && empty1)) pop_empty <= 1'b1;
    end

    // Wire log: {er, en, txd} per cycle
    logic [9:0] lg0 [0:8191];
    logic [9:0] lg1 [0:8191];
    int n = 0;
    always @(negedge clk) begin
        if (n < 8192) begin
            lg0[n] <= {er0, en0, txd0};
            lg1[n] <= {er1, en1, txd1};
        end
        n <= n + 1;
    end

    int total = 0;
    int bad = 0;
    logic [7:0] exp_b [0:255];
    int exp_len;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        total++;
        assert (obs === expv) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    function automatic logic [9:0] lg(input int inst, input int i);
        if (i < 0 || i > 8191) return 10'h3FF;
        return (inst == 0) ? lg0[i] : lg1[i];
    endfunction

    task automatic push0(input logic [8:0] w);
        mem0[wp0[9:0]] = w;
        wp0++;
    endtask

    task automatic push1(input logic [8:0] w);
        mem1[wp1[9:0]] = w;
        wp1++;
    endtask

    task automatic exp_pre();
        exp_len = 0;
        for (int i = 0; i < 7; i++) begin
            exp_b[exp_len] = 8'h55;
            exp_len++;
        end
        exp_b[exp_len] = 8'hD5;
        exp_len++;
    endtask

    task automatic exp_add(input logic [7:0] b);
        exp_b[exp_len] = b;
        exp_len++;
    endtask

    // Finds the first tx_en cycle at or after 'from', checks exp_b on the wire,
    // optionally checks 12 quiet cycles after it.
    task automatic check_frame(input int inst, input int from, input string tag,
                               input bit chk_idle, output int s_out);
        int s;
        int idle;
        logic [9:0] w;
        s = -1;
        for (int i = from; i < n - 2; i++) begin
            w = lg(inst, i);
            if (s < 0 && w[8]) s = i;
        end
        chk($sformatf("%s start", tag), 32'(s >= 0), 32'd1);
        if (s < 0) s = from;
        for (int i = 0; i < exp_len; i++)
            chk($sformatf("%s byte%0d", tag, i), 32'(lg(inst, s + i)), {22'd0, 2'b01, exp_b[i]});
        if (chk_idle) begin
            idle = 0;
            for (int j = 0; j < 12; j++)
                if (lg(inst, s + exp_len + j) == 10'h000) idle++;
            chk($sformatf("%s idle", tag), 32'(idle), 32'd12);
        end
        s_out = s;
    endtask

    int from, sa, sb, cnt;

    initial begin
        // reset
        repeat (3) @(negedge clk);
        chk("rst wire", {22'd0, er0, en0, txd0}, 32'd0);
        chk("rst rd_en", {31'd0, rd_en0}, 32'd0);
        chk("rst cnts", {fcnt0, ucnt0}, 32'd0);
        chk("rd_clk", {30'd0, rd_clk0, rd_clk1}, {30'd0, clk, clk});
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        chk("idle wire", {22'd0, er0, en0, txd0}, 32'd0);

        // 64-byte frame
        from = n;
        for (int i = 0; i < 64; i++) push0({(i == 63), 8'(i)});
        repeat (110) @(negedge clk);
        exp_pre();
        for (int i = 0; i < 64; i++) exp_add(8'(i));
        check_frame(0, from, "f64", 1'b1, sa);
        chk("f64 frame_cnt", 32'(fcnt0), 32'd1);

        // 10-byte frame, padded and unpadded
        from = n;
        for (int i = 0; i < 10; i++) begin
            push0({(i == 9), 8'hA0 + 8'(i)});
            push1({(i == 9), 8'hA0 + 8'(i)});
        end
        repeat (110) @(negedge clk);
        exp_pre();
        for (int i = 0; i < 10; i++) exp_add(8'hA0 + 8'(i));
        for (int i = 0; i < 50; i++) exp_add(8'h00);
        check_frame(0, from, "pad10", 1'b1, sa);
        chk("pad10 frame_cnt", 32'(fcnt0), 32'd2);
        exp_pre();
        for (int i = 0; i < 10; i++) exp_add(8'hA0 + 8'(i));
        check_frame(1, from, "nopad10", 1'b1, sa);
        chk("nopad10 frame_cnt", 32'(fcnt1), 32'd1);

        // back-to-back frames
        from = n;
        for (int i = 0; i < 64; i++) push0({(i == 63), 8'h80 + 8'(i)});
        for (int i = 0; i < 60; i++) push0({(i == 59), 8'(i * 3)});
        repeat (220) @(negedge clk);
        exp_pre();
        for (int i = 0; i < 64; i++) exp_add(8'h80 + 8'(i));
        check_frame(0, from, "b2b A", 1'b1, sa);
        exp_pre();
        for (int i = 0; i < 60; i++) exp_add(8'(i * 3));
        check_frame(0, sa + 72, "b2b B", 1'b1, sb);
        chk("b2b gap", 32'(sb - (sa + 72)), 32'd12);
        chk("b2b frame_cnt", 32'(fcnt0), 32'd4);

        // underrun after 5 data bytes, tail arrives later
        from = n;
        for (int i = 0; i < 5; i++) push0({1'b0, 8'h31 + 8'(i)});
        repeat (50) @(negedge clk);
        exp_pre();
        for (int i = 0; i < 5; i++) exp_add(8'h31 + 8'(i));
        check_frame(0, from, "urun", 1'b0, sa);
        chk("urun err cycle", 32'(lg(0, sa + 13)), 32'h300);
        push0({1'b0, 8'h36});
        push0({1'b0, 8'h37});
        push0({1'b1, 8'h38});
        repeat (40) @(negedge clk);
        cnt = 0;
        for (int i = sa + 14; i < n - 2; i++)
            if (lg(0, i) != 10'h000) cnt++;
        chk("urun quiet after", 32'(cnt), 32'd0);
        chk("urun drained", {31'd0, empty0}, 32'd1);
        chk("urun underrun_cnt", 32'(ucnt0), 32'd1);
        chk("urun frame_cnt", 32'(fcnt0), 32'd4);

        // reset in the middle of DATA
        for (int i = 0; i < 30; i++) push0({(i == 29), 8'h60 + 8'(i)});
        repeat (14) @(negedge clk);
        chk("mid in frame", {31'd0, en0}, 32'd1);
        rst_n = 1'b0;
        flush0 = 1'b1;
        @(negedge clk);
        chk("mid rst wire", {22'd0, er0, en0, txd0}, 32'd0);
        chk("mid rst rd_en", {31'd0, rd_en0}, 32'd0);
        chk("mid rst cnts", {fcnt0, ucnt0}, 32'd0);
        rst_n = 1'b1;
        flush0 = 1'b0;
        repeat (3) @(negedge clk);
        from = n;
        for (int i = 0; i < 20; i++) push0({(i == 19), 8'hC0 + 8'(i)});
        repeat (100) @(negedge clk);
        exp_pre();
        for (int i = 0; i < 20; i++) exp_add(8'hC0 + 8'(i));
        for (int i = 0; i < 40; i++) exp_add(8'h00);
        check_frame(0, from, "post rst", 1'b1, sa);
        chk("post rst frame_cnt", 32'(fcnt0), 32'd1);

        // 1-byte frame
        from = n;
        push0({1'b1, 8'h77});
        repeat (100) @(negedge clk);
        exp_pre();
        exp_add(8'h77);
        for (int i = 0; i < 59; i++) exp_add(8'h00);
        check_frame(0, from, "f1", 1'b1, sa);
        chk("f1 frame_cnt", 32'(fcnt0), 32'd2);
        chk("f1 underrun_cnt", 32'(ucnt0), 32'd0);
        chk("nopad underrun_cnt", 32'(ucnt1), 32'd0);
        chk("no pop on empty", {31'd0, pop_empty}, 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
